i2c_master_arbiter: RTL and testbench
=====================================

// Module: i2c_master_arbiter
// PURPOSE
// - Round-robin arbiter/sequencer sharing one i2c_master between G_NB_REQ requesters.
// - Per granted request: fills i2c_master FIFO TX, pulses start, tracks busy, drains FIFO RX back to the requester.
// - Sits between system requesters (e.g. EEPROM/sensor pollers) and the i2c_master control/FIFO ports.
// PARAMETERS
// - G_NB_REQ        2      number of requesters (>=2)
// - G_NB_DATA       16     max bytes per transaction; NBW = $clog2(G_NB_DATA)+1
// - G_START_TIMEOUT 1024   clk_sys cycles allowed between start pulse and busy rising
// PORTS
// - clk_sys            in   1          system clock
// - rst_sys            in   1          reset, asynchronous, active-high
// - req                in   N          per-requester request; hold with cmd until own done
// - rw                 in   N          per-requester 1=read, 0=write
// - chip_addr          in   7*N        per-requester 7-bit slave address, flattened
// - nb_data            in   NBW*N      per-requester byte count, flattened
// - wdata              in   8*N        per-requester write byte; next byte presented after wdata_pop
// - wdata_pop          out  N          one-hot, 1 cycle: current wdata byte consumed
// - rdata              out  8          read byte, shared bus
// - rdata_valid        out  N          one-hot, 1 cycle: rdata valid for that requester
// - done               out  N          one-hot, 1 cycle: transaction finished
// - error              out  1          valid with done: NACK or start timeout
// - m_start / m_rw / m_chip_addr / m_nb_data   out 1/1/7/NBW   i2c_master command
// - m_wr_en_fifo_tx / m_wdata_fifo_tx          out 1/8         i2c_master FIFO TX write
// - m_fifo_full_fifo_tx                        in  1
// - m_rd_en_fifo_rx  out 1 ; m_rdata_fifo_rx in 8 ; m_fifo_empty_fifo_rx in 1
// - m_sack_error in 1 ; m_busy in 1
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, RR pointer = N-1 (requester 0 wins first), counters 0.
// - FSM: IDLE -> LOAD -> START -> WAIT_H -> WAIT_L -> DRAIN -> DONE -> IDLE.
// - IDLE: any req -> grant first set bit searching from ptr+1 modulo N; latch rw/addr/nb_data of winner; ptr<=winner.
// - m_rw/m_chip_addr/m_nb_data driven from latched values from grant to DONE; 0 otherwise.
// - LOAD: write and nb_data>0 only; each cycle with fifo_full=0: m_wr_en_fifo_tx=1, m_wdata=wdata[winner],
//   wdata_pop[winner]=1 same cycle, byte count++; full=1 -> stall, no pop. Leave after nb_data bytes. Else skip.
// - START: m_start=1 exactly one cycle; timeout counter cleared.
// - WAIT_H: busy=1 -> WAIT_L; counter reaches G_START_TIMEOUT-1 -> DONE with error=1 (no drain).
// - WAIT_L: busy=0 -> latch m_sack_error as err; -> DRAIN.
// - DRAIN, read & !err: m_rd_en_fifo_rx=1 when !empty and popped<nb_data; FIFO read latency 1:
//   rdata/rdata_valid[winner] asserted the cycle after each rd_en. Leave when nb_data bytes returned.
// - DRAIN, err=1 (any rw): pop FIFO RX until empty, no rdata_valid (flush stale data). Write & !err: skip.
// - DRAIN, read & !err, FIFO empty before nb_data returned: wait (no timeout; master guarantees fill).
// - DONE: done[winner]=1, error=err for one cycle; -> IDLE. Earliest re-grant next cycle.
// - nb_data=0: address-only; LOAD and DRAIN skipped. nb_data>G_NB_DATA: clamped to G_NB_DATA.
// - req dropped mid-transaction: ignored; transaction completes, done still pulsed.
// - req rising during a transaction: waits; arbitrated only in IDLE.
// - Reset mid-operation: immediate return to reset state; i2c_master FIFOs not flushed here (master reset is shared).
// - At most one bit of wdata_pop/rdata_valid/done set at any cycle.
// TESTING
// - Write: req0, rw=0, addr=0x50, nb_data=3, wdata 0xA1,0xA2,0xA3 -> 3 FIFO TX writes in order, 1 start, done[0], error=0.
// - Read: req1, rw=1, addr=0x50, nb_data=2, slave returns 0x11,0x22 -> rdata_valid[1] twice with 0x11,0x22, done[1].
// - Fairness: req0,req1 held high, 4 transactions -> grant order 0,1,0,1.
// - NACK: slave absent at addr 0x7F, read nb_data=2 -> done error=1, no rdata_valid, FIFO RX empty after.
// - Timeout: busy tied 0 -> done error=1 exactly G_START_TIMEOUT cycles after m_start.
// - Backpressure+reset: fifo_full held 5 cycles in LOAD -> no pops meanwhile; rst_sys mid-WAIT_L -> all outputs 0, IDLE.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin sequencer sharing one i2c_master among G_NB_REQ requesters: load TX FIFO, start, wait busy, drain RX FIFO.
// Command fields follow the grant by one cycle; TX loading stalls on fifo_full, RX drain waits on fifo_empty.
module i2c_master_arbiter #(
    parameter int G_NB_REQ        = 2,
    parameter int G_NB_DATA       = 16,
    parameter int G_START_TIMEOUT = 1024,
    localparam int NBW            = $clog2(G_NB_DATA) + 1
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic [G_NB_REQ-1:0]     req,
    input  logic [G_NB_REQ-1:0]     rw,
    input  logic [7*G_NB_REQ-1:0]   chip_addr,
    input  logic [NBW*G_NB_REQ-1:0] nb_data,
    input  logic [8*G_NB_REQ-1:0]   wdata,
    output logic [G_NB_REQ-1:0]     wdata_pop,
    output logic [7:0]              rdata,
    output logic [G_NB_REQ-1:0]     rdata_valid,
    output logic [G_NB_REQ-1:0]     done,
    output logic                    error,
    output logic                    m_start,
    output logic                    m_rw,
    output logic [6:0]              m_chip_addr,
    output logic [NBW-1:0]          m_nb_data,
    output logic                    m_wr_en_fifo_tx,
    output logic [7:0]              m_wdata_fifo_tx,
    input  logic                    m_fifo_full_fifo_tx,
    output logic                    m_rd_en_fifo_rx,
    input  logic [7:0]              m_rdata_fifo_rx,
    input  logic                    m_fifo_empty_fifo_rx,
    input  logic                    m_sack_error,
    input  logic                    m_busy
);

    localparam int IW = (G_NB_REQ > 1) ? $clog2(G_NB_REQ) : 1;
    localparam int TW = $clog2(G_START_TIMEOUT + 1);
    localparam logic [NBW-1:0] NB_MAX  = NBW'(G_NB_DATA);
    localparam logic [TW-1:0]  TO_LAST = TW'(G_START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_H, S_WAIT_L, S_DRAIN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d, win_q, win_d;
    logic           rw_q, rw_d;
    logic [6:0]     addr_q, addr_d;
    logic [NBW-1:0] nb_q, nb_d, cnt_q, cnt_d, ret_q, ret_d;
    logic [TW-1:0]  to_q, to_d;
    logic           err_q, err_d;
    logic           rvld_q, rvld_d;

    logic [6:0]     addr_a [G_NB_REQ];
    logic [NBW-1:0] nb_a   [G_NB_REQ];
    logic [7:0]     wd_a   [G_NB_REQ];

    for (genvar g = 0; g < G_NB_REQ; g++) begin : g_unpack
        assign addr_a[g] = chip_addr[g*7 +: 7];
        assign nb_a[g]   = nb_data[g*NBW +: NBW];
        assign wd_a[g]   = wdata[g*8 +: 8];
    end

    // Search starts just after the last winner so every requester gets a turn.
    logic           grant_vld;
    logic [IW-1:0]  grant_idx, cand;
    logic [NBW-1:0] nb_sel;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= G_NB_REQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % G_NB_REQ);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        nb_sel = (nb_a[grant_idx] > NB_MAX) ? NB_MAX : nb_a[grant_idx];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        nb_d    = nb_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        to_d    = to_q;
        err_d   = err_q;
        rvld_d  = 1'b0;
        wdata_pop       = '0;
        rdata_valid     = '0;
        done            = '0;
        error           = 1'b0;
        m_start         = 1'b0;
        m_wr_en_fifo_tx = 1'b0;
        m_wdata_fifo_tx = '0;
        m_rd_en_fifo_rx = 1'b0;
        if (rvld_q) begin
            rdata_valid[win_q] = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    ptr_d   = grant_idx;
                    win_d   = grant_idx;
                    rw_d    = rw[grant_idx];
                    addr_d  = addr_a[grant_idx];
                    nb_d    = nb_sel;
                    cnt_d   = '0;
                    ret_d   = '0;
                    err_d   = 1'b0;
                    state_d = (!rw[grant_idx] && nb_sel != '0) ? S_LOAD : S_START;
                end
            end
            S_LOAD: begin
                if (!m_fifo_full_fifo_tx) begin
                    m_wr_en_fifo_tx  = 1'b1;
                    m_wdata_fifo_tx  = wd_a[win_q];
                    wdata_pop[win_q] = 1'b1;
                    cnt_d            = cnt_q + NBW'(1);
                    if (cnt_d == nb_q) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                m_start = 1'b1;
                to_d    = '0;
                state_d = S_WAIT_H;
            end
            S_WAIT_H: begin
                if (m_busy) begin
                    state_d = S_WAIT_L;
                end else begin
                    to_d = to_q + TW'(1);
                    if (to_d == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_L: begin
                if (!m_busy) begin
                    err_d   = m_sack_error;
                    cnt_d   = '0;
                    ret_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (err_q) begin
                    // Failed transfer: discard whatever the master left behind.
                    if (m_fifo_empty_fifo_rx) begin
                        state_d = S_DONE;
                    end else begin
                        m_rd_en_fifo_rx = 1'b1;
                    end
                end else if (!rw_q || nb_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    if (!m_fifo_empty_fifo_rx && cnt_q < nb_q) begin
                        m_rd_en_fifo_rx = 1'b1;
                        rvld_d          = 1'b1;
                        cnt_d           = cnt_q + NBW'(1);
                    end
                    if (rvld_q) begin
                        ret_d = ret_q + NBW'(1);
                    end
                    if (ret_d == nb_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done[win_q] = 1'b1;
                error       = err_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata       = rvld_q ? m_rdata_fifo_rx : 8'h00;
    assign m_rw        = (state_q != S_IDLE) ? rw_q : 1'b0;
    assign m_chip_addr = (state_q != S_IDLE) ? addr_q : 7'h00;
    assign m_nb_data   = (state_q != S_IDLE) ? nb_q : '0;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(G_NB_REQ - 1);
            win_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            nb_q    <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            to_q    <= to_d;
            err_q   <= err_d;
            rvld_q  <= rvld_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter with a behavioural i2c_master (FIFOs, busy, ack) and queue-based scoreboard.
module tb_i2c_master_arbiter;
    localparam int N   = 2;
    localparam int TO  = 1024;
    localparam int NBW = 5;

    logic clk_sys = 1'b0;
    logic rst_sys;
    logic [N-1:0] req, rw;
    logic [7*N-1:0] chip_addr;
    logic [NBW*N-1:0] nb_data;
    logic [8*N-1:0] wdata;
    logic [N-1:0] wdata_pop, rdata_valid, done;
    logic [7:0] rdata;
    logic error, m_start, m_rw, m_wr_en_fifo_tx, m_rd_en_fifo_rx;
    logic [6:0] m_chip_addr;
    logic [NBW-1:0] m_nb_data;
    logic [7:0] m_wdata_fifo_tx, m_rdata_fifo_rx;
    logic m_fifo_full_fifo_tx, m_fifo_empty_fifo_rx, m_sack_error, m_busy;

    always #5 clk_sys = ~clk_sys;

    i2c_master_arbiter #(.G_NB_REQ(N), .G_NB_DATA(16), .G_START_TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .req(req), .rw(rw), .chip_addr(chip_addr),
        .nb_data(nb_data), .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata),
        .rdata_valid(rdata_valid), .done(done), .error(error), .m_start(m_start), .m_rw(m_rw),
        .m_chip_addr(m_chip_addr), .m_nb_data(m_nb_data), .m_wr_en_fifo_tx(m_wr_en_fifo_tx),
        .m_wdata_fifo_tx(m_wdata_fifo_tx), .m_fifo_full_fifo_tx(m_fifo_full_fifo_tx),
        .m_rd_en_fifo_rx(m_rd_en_fifo_rx), .m_rdata_fifo_rx(m_rdata_fifo_rx),
        .m_fifo_empty_fifo_rx(m_fifo_empty_fifo_rx), .m_sack_error(m_sack_error), .m_busy(m_busy)
    );

    logic [38:0] all_out;
    assign all_out = {wdata_pop, rdata, rdata_valid, done, error, m_start, m_rw, m_chip_addr,
                      m_nb_data, m_wr_en_fifo_tx, m_wdata_fifo_tx, m_rd_en_fifo_rx};

    int total = 0, bad = 0, cyc = 0;
    logic [7:0] exp_tx[$], obs_tx[$];
    logic [8:0] exp_rd[$], obs_rd[$];
    logic [1:0] exp_done[$], obs_done[$];
    logic       obs_err[$];
    int         obs_done_cyc[$];
    int start_cnt, start_cyc, pops_while_full = 0, onehot_bad = 0;
    logic [6:0] start_addr;
    logic [NBW-1:0] start_nb;
    logic start_rw;

    // master model state
    logic [7:0] wq0[$], wq1[$], slave_q[$], rx_q[$];
    bit busy_tie0 = 0, nack = 0, cur_rw = 0;
    int busy_phase = 0, busy_cnt = 0, full_hold = 0, full_left = 0;
    logic [N-1:0] saw_pop;
    logic saw_wr, saw_rd, saw_start;

    initial begin
        m_fifo_full_fifo_tx = 0; m_fifo_empty_fifo_rx = 1; m_sack_error = 0; m_busy = 0;
        m_rdata_fifo_rx = 0; wdata = '0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            saw_pop = wdata_pop; saw_wr = m_wr_en_fifo_tx; saw_rd = m_rd_en_fifo_rx; saw_start = m_start;
            if (m_wr_en_fifo_tx) obs_tx.push_back(m_wdata_fifo_tx);
            if (m_fifo_full_fifo_tx && wdata_pop != 0) pops_while_full++;
            if (m_start) begin
                start_cnt++; start_cyc = cyc; start_addr = m_chip_addr; start_nb = m_nb_data; start_rw = m_rw;
            end
            if (rdata_valid != 0) obs_rd.push_back({rdata_valid[1], rdata});
            if (done != 0) begin
                obs_done.push_back(done); obs_err.push_back(error); obs_done_cyc.push_back(cyc);
            end
            if ($countones(done) > 1 || $countones(rdata_valid) > 1 || $countones(wdata_pop) > 1) onehot_bad++;
            @(posedge clk_sys);
            #1;
            if (rst_sys) begin
                m_busy = 0; busy_phase = 0; full_left = 0; m_fifo_full_fifo_tx = 0;
                rx_q.delete(); m_rdata_fifo_rx = 0;
            end else begin
                if (saw_pop[0] && wq0.size() > 0) void'(wq0.pop_front());
                if (saw_pop[1] && wq1.size() > 0) void'(wq1.pop_front());
                if (saw_wr && full_hold > 0) begin full_left = full_hold; full_hold = 0; end
                if (full_left > 0) begin m_fifo_full_fifo_tx = 1; full_left--; end
                else m_fifo_full_fifo_tx = 0;
                if (saw_rd && rx_q.size() > 0) m_rdata_fifo_rx = rx_q.pop_front();
                if (saw_start && !busy_tie0) begin
                    busy_phase = 1; busy_cnt = 2; cur_rw = start_rw;
                end else if (busy_phase == 1) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin m_busy = 1; busy_phase = 2; busy_cnt = 4; end
                end else if (busy_phase == 2) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        m_busy = 0; busy_phase = 0;
                        if (cur_rw) begin
                            if (nack) rx_q.push_back(8'hEE);
                            else while (slave_q.size() > 0) rx_q.push_back(slave_q.pop_front());
                        end
                    end
                end
            end
            m_fifo_empty_fifo_rx = (rx_q.size() == 0);
            m_sack_error = nack;
            wdata = {(wq1.size() > 0) ? wq1[0] : 8'h00, (wq0.size() > 0) ? wq0[0] : 8'h00};
        end
    end

    task automatic clear_sb();
        exp_tx.delete(); obs_tx.delete(); exp_rd.delete(); obs_rd.delete();
        exp_done.delete(); obs_done.delete(); obs_err.delete(); obs_done_cyc.delete();
        start_cnt = 0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget && obs_done.size() < n; i++) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst_sys = 1; req = 0; rw = 0; chip_addr = 0; nb_data = 0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        @(posedge clk_sys); #1; rst_sys = 0;
        repeat (2) @(negedge clk_sys);
        total++; if (all_out !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_write();
        logic [7:0] e;
        clear_sb();
        wq0 = '{8'hA1, 8'hA2, 8'hA3}; exp_tx = '{8'hA1, 8'hA2, 8'hA3}; exp_done.push_back(2'b01);
        rw = 2'b00; chip_addr[6:0] = 7'h50; nb_data[4:0] = 5'd3; req = 2'b01;
        wait_dones(1, 200); req = 0;
        total++; if (obs_done.size() != 1) begin bad++; $display("FAIL wr_done_cnt: got %0d want 1", obs_done.size()); end
        else begin
            total++; if (obs_done[0] !== exp_done[0]) begin bad++; $display("FAIL wr_done: got %b want %b", obs_done[0], exp_done[0]); end
            total++; if (obs_err[0] !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", obs_err[0]); end
        end
        total++; if (obs_tx.size() != 3) begin bad++; $display("FAIL wr_tx_cnt: got %0d want 3", obs_tx.size()); end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            total++; if (obs_tx.size() == 0 || obs_tx[0] !== e) begin
                bad++; $display("FAIL wr_tx_byte: got %h want %h", (obs_tx.size() > 0) ? obs_tx[0] : 8'hxx, e); end
            if (obs_tx.size() > 0) void'(obs_tx.pop_front());
        end
        total++; if (start_cnt != 1) begin bad++; $display("FAIL wr_starts: got %0d want 1", start_cnt); end
        total++; if (start_addr !== 7'h50 || start_rw !== 1'b0) begin
            bad++; $display("FAIL wr_cmd: got addr %h rw %b want 50 0", start_addr, start_rw); end
    endtask

    task automatic test_read();
        logic [8:0] e;
        clear_sb();
        slave_q = '{8'h11, 8'h22}; exp_rd = '{{1'b1, 8'h11}, {1'b1, 8'h22}};
        rw = 2'b10; chip_addr[13:7] = 7'h50; nb_data[9:5] = 5'd2; req = 2'b10;
        wait_dones(1, 200); req = 0;
        total++; if (obs_done.size() != 1 || obs_done[0] !== 2'b10 || obs_err[0] !== 1'b0) begin
            bad++; $display("FAIL rd_done: got cnt %0d want one done[1] without error", obs_done.size()); end
        total++; if (obs_rd.size() != 2) begin bad++; $display("FAIL rd_cnt: got %0d want 2", obs_rd.size()); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            total++; if (obs_rd.size() == 0 || obs_rd[0] !== e) begin
                bad++; $display("FAIL rd_byte: got %h want %h", (obs_rd.size() > 0) ? obs_rd[0] : 9'hxxx, e); end
            if (obs_rd.size() > 0) void'(obs_rd.pop_front());
        end
        total++; if (obs_tx.size() != 0) begin bad++; $display("FAIL rd_no_tx: got %0d want 0", obs_tx.size()); end
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        logic [1:0] d;
        clear_sb();
        wq0 = '{8'h30, 8'h31}; wq1 = '{8'h40, 8'h41};
        exp_tx = '{8'h30, 8'h40, 8'h31, 8'h41}; exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
        rw = 2'b00; chip_addr = {7'h21, 7'h22}; nb_data = {5'd1, 5'd1}; req = 2'b11;
        wait_dones(4, 400); req = 0;
        total++; if (obs_done.size() != 4) begin bad++; $display("FAIL rr_cnt: got %0d want 4", obs_done.size()); end
        while (exp_done.size() > 0) begin
            d = exp_done.pop_front();
            total++; if (obs_done.size() == 0 || obs_done[0] !== d) begin
                bad++; $display("FAIL rr_order: got %b want %b", (obs_done.size() > 0) ? obs_done[0] : 2'bxx, d); end
            if (obs_done.size() > 0) void'(obs_done.pop_front());
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            total++; if (obs_tx.size() == 0 || obs_tx[0] !== e) begin
                bad++; $display("FAIL rr_tx_byte: got %h want %h", (obs_tx.size() > 0) ? obs_tx[0] : 8'hxx, e); end
            if (obs_tx.size() > 0) void'(obs_tx.pop_front());
        end
    endtask

    task automatic test_nack();
        clear_sb();
        nack = 1;
        rw = 2'b01; chip_addr[6:0] = 7'h7F; nb_data[4:0] = 5'd2; req = 2'b01;
        wait_dones(1, 200); req = 0; nack = 0;
        total++; if (obs_done.size() != 1 || obs_done[0] !== 2'b01) begin
            bad++; $display("FAIL nack_done: got cnt %0d want one done[0]", obs_done.size()); end
        total++; if (obs_err.size() == 0 || obs_err[0] !== 1'b1) begin bad++; $display("FAIL nack_err: got 0 want 1"); end
        total++; if (obs_rd.size() != 0) begin bad++; $display("FAIL nack_rdata: got %0d want 0", obs_rd.size()); end
        @(posedge clk_sys); #1;
        total++; if (rx_q.size() != 0 || m_fifo_empty_fifo_rx !== 1'b1) begin
            bad++; $display("FAIL nack_flush: got %0d bytes left want 0", rx_q.size()); end
    endtask

    task automatic test_timeout();
        clear_sb();
        busy_tie0 = 1;
        rw = 2'b00; chip_addr[13:7] = 7'h33; nb_data[9:5] = 5'd0; req = 2'b10;
        wait_dones(1, 1500); req = 0; busy_tie0 = 0;
        total++; if (obs_done.size() != 1 || obs_done[0] !== 2'b10 || obs_err[0] !== 1'b1) begin
            bad++; $display("FAIL to_done: got cnt %0d want one done[1] with error", obs_done.size()); end
        else begin
            total++; if (obs_done_cyc[0] - start_cyc != TO) begin
                bad++; $display("FAIL to_delay: got %0d want %0d", obs_done_cyc[0] - start_cyc, TO); end
        end
        total++; if (start_nb !== 5'd0 || obs_tx.size() != 0) begin
            bad++; $display("FAIL to_addr_only: got nb %0d tx %0d want 0 0", start_nb, obs_tx.size()); end
    endtask

    task automatic test_clamp();
        clear_sb();
        wq0.delete();
        for (int i = 0; i < 18; i++) wq0.push_back(8'(8'h60 + i));
        rw = 2'b00; chip_addr[6:0] = 7'h44; nb_data[4:0] = 5'd20; req = 2'b01;
        wait_dones(1, 300); req = 0;
        total++; if (obs_tx.size() != 16) begin bad++; $display("FAIL clamp_tx: got %0d want 16", obs_tx.size()); end
        total++; if (start_nb !== 5'd16) begin bad++; $display("FAIL clamp_nb: got %0d want 16", start_nb); end
        total++; if (obs_tx.size() > 0 && obs_tx[obs_tx.size()-1] !== 8'h6F) begin
            bad++; $display("FAIL clamp_last: got %h want 6f", obs_tx[obs_tx.size()-1]); end
        wq0.delete();
    endtask

    task automatic test_backpressure_reset();
        clear_sb();
        pops_while_full = 0; full_hold = 5;
        wq0 = '{8'hB1, 8'hB2, 8'hB3};
        rw = 2'b00; chip_addr[6:0] = 7'h20; nb_data[4:0] = 5'd3; req = 2'b01;
        for (int i = 0; i < 100 && m_busy !== 1'b1; i++) @(posedge clk_sys);
        #1; rst_sys = 1; req = 0;
        @(negedge clk_sys);
        total++; if (all_out !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", all_out); end
        total++; if (pops_while_full != 0) begin bad++; $display("FAIL bp_pops: got %0d want 0", pops_while_full); end
        total++; if (obs_tx.size() != 3 || obs_tx[0] !== 8'hB1 || obs_tx[2] !== 8'hB3) begin
            bad++; $display("FAIL bp_tx: got %0d bytes want 3 (b1..b3)", obs_tx.size()); end
        @(posedge clk_sys); #1; rst_sys = 0;
        repeat (10) @(posedge clk_sys);
        #1;
        total++; if (obs_done.size() != 0 || all_out !== '0) begin
            bad++; $display("FAIL rst_idle: got %0d dones outputs %h want 0 0", obs_done.size(), all_out); end
        clear_sb();
        rw = 2'b00; nb_data = '0; req = 2'b11;
        wait_dones(1, 200); req = 0;
        total++; if (obs_done.size() == 0 || obs_done[0] !== 2'b01) begin
            bad++; $display("FAIL rst_ptr: got %b want 01", (obs_done.size() > 0) ? obs_done[0] : 2'bxx); end
        repeat (20) @(posedge clk_sys);
    endtask

    task automatic test_onehot();
        total++; if (onehot_bad != 0) begin bad++; $display("FAIL onehot: got %0d violations want 0", onehot_bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_nack();
        test_timeout();
        test_clamp();
        test_backpressure_reset();
        test_onehot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
